// File: rtl/recepcao_movimentos_if.sv
// recepcao_movimentos_if: signal bundle between the move receiver and its
// surroundings (host UART line, arm pulse, move-RAM write port and status).
// master: the receiver itself. slave: whoever drives rx/iniciar and consumes
// the RAM write port and status outputs.
interface recepcao_movimentos_if;
    logic       iniciar;
    logic       rx_serial;
    logic       we_mov;
    logic [8:0] addr_mov;
    logic [4:0] data_mov;
    logic [8:0] num_movimentos;
    logic       pronto;
    logic       erro;
    logic [3:0] db_estado;

    modport master (
        input  iniciar,
        input  rx_serial,
        output we_mov,
        output addr_mov,
        output data_mov,
        output num_movimentos,
        output pronto,
        output erro,
        output db_estado
    );

    modport slave (
        output iniciar,
        output rx_serial,
        input  we_mov,
        input  addr_mov,
        input  data_mov,
        input  num_movimentos,
        input  pronto,
        input  erro,
        input  db_estado
    );
endinterface

// File: rtl/recepcao_movimentos.sv
// recepcao_movimentos: UART receiver for the solver's move list. Each valid
// byte (<= MAX_CODE) is written to the move RAM at address = move count;
// END_CODE terminates the list and pulses pronto. Bad codes, framing errors
// and RAM overflow park the FSM in ERRO until the next iniciar.
// Optional feature: define RECEPCAO_PARIDADE_EN for 8E1 frames (even parity);
// otherwise frames are 8N1 and the PARIDADE state is compiled out.
module recepcao_movimentos #(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          MAX_MOV      = 480,
    parameter int          MAX_CODE     = 17,
    parameter logic [7:0]  END_CODE     = 8'hFF
) (
    input  logic                    clock,
    input  logic                    reset,
    recepcao_movimentos_if.master   bus
);

    localparam int TW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        ESPERA   = 4'd1,
        START    = 4'd2,
        DADOS    = 4'd3,
        PARIDADE = 4'd4,
        STOP     = 4'd5,
        AVALIA   = 4'd6,
        ARMAZENA = 4'd7,
        FIM      = 4'd8,
        ERRO     = 4'd9
    } estado_t;

    estado_t       state_reg, state_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic [2:0]    bit_reg, bit_next;
    logic [7:0]    shift_reg, shift_next;
    logic [8:0]    count_reg, count_next;
    logic          pronto_reg, pronto_next;
    logic          rx_meta_reg, rx_sync_reg;
    logic          rx;

    assign rx = rx_sync_reg;

    // Two-flop synchronizer on the UART pin; idles high so reset never looks like a start bit
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
        end else begin
            rx_meta_reg <= bus.rx_serial;
            rx_sync_reg <= rx_meta_reg;
        end
    end

    // State and datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            timer_reg  <= '0;
            bit_reg    <= '0;
            shift_reg  <= '0;
            count_reg  <= '0;
            pronto_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            timer_reg  <= timer_next;
            bit_reg    <= bit_next;
            shift_reg  <= shift_next;
            count_reg  <= count_next;
            pronto_reg <= pronto_next;
        end
    end

    // Next-state and datapath updates; bit timer restarts at every sample point
    always_comb begin
        state_next  = state_reg;
        timer_next  = timer_reg;
        bit_next    = bit_reg;
        shift_next  = shift_reg;
        count_next  = count_reg;
        pronto_next = 1'b0;

        case (state_reg)
            IDLE, FIM, ERRO: begin
                if (bus.iniciar) begin
                    state_next = ESPERA;
                    count_next = '0;
                end
            end
            ESPERA: begin
                if (!rx) begin
                    state_next = START;
                    timer_next = '0;
                end
            end
            START: begin
                if (timer_reg == HALF_LAST) begin
                    timer_next = '0;
                    bit_next   = '0;
                    state_next = rx ? ESPERA : DADOS;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            DADOS: begin
                if (timer_reg == BIT_LAST) begin
                    timer_next = '0;
                    shift_next = {rx, shift_reg[7:1]};
                    bit_next   = bit_reg + 1'b1;
                    if (bit_reg == 3'd7) begin
`ifdef RECEPCAO_PARIDADE_EN
                        state_next = PARIDADE;
`else
                        state_next = STOP;
`endif
                    end
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
`ifdef RECEPCAO_PARIDADE_EN
            PARIDADE: begin
                if (timer_reg == BIT_LAST) begin
                    timer_next = '0;
                    state_next = (^{shift_reg, rx}) ? ERRO : STOP;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
`endif
            STOP: begin
                if (timer_reg == BIT_LAST) begin
                    timer_next = '0;
                    state_next = rx ? AVALIA : ERRO;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            AVALIA: begin
                if (shift_reg == END_CODE) begin
                    state_next  = FIM;
                    pronto_next = 1'b1;
                end else if (shift_reg > 8'(MAX_CODE)) begin
                    state_next = ERRO;
                end else if (count_reg == 9'(MAX_MOV)) begin
                    state_next = ERRO;
                end else begin
                    state_next = ARMAZENA;
                end
            end
            ARMAZENA: begin
                count_next = count_reg + 1'b1;
                state_next = ESPERA;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs: write strobe and error level decode straight from the state
    assign bus.we_mov         = (state_reg == ARMAZENA);
    assign bus.addr_mov       = count_reg;
    assign bus.data_mov       = shift_reg[4:0];
    assign bus.num_movimentos = count_reg;
    assign bus.pronto         = pronto_reg;
    assign bus.erro           = (state_reg == ERRO);
    assign bus.db_estado      = state_reg;

endmodule

// File: tb/tb_recepcao_movimentos.sv
// tb_recepcao_movimentos: directed test of the move receiver at
// CLKS_PER_BIT=8, MAX_MOV=4. Parity cases are built when
// RECEPCAO_PARIDADE_EN is defined.
module tb_recepcao_movimentos;

    localparam int CPB = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    recepcao_movimentos_if bus ();

    recepcao_movimentos #(
        .CLKS_PER_BIT (CPB),
        .MAX_MOV      (4),
        .MAX_CODE     (17),
        .END_CODE     (8'hFF)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observer: records RAM writes and pronto pulses, sampled on the falling edge
    int         wr_cnt     = 0;
    logic [8:0] wr_addr [64];
    logic [4:0] wr_data [64];
    int         pronto_cnt = 0;
    logic [8:0] pronto_num = '0;
    int         past_start = 0;
    int         in_start   = 0;

    always @(negedge clock) begin
        if (bus.we_mov) begin
            if (wr_cnt < 64) begin
                wr_addr[wr_cnt] = bus.addr_mov;
                wr_data[wr_cnt] = bus.data_mov;
            end
            $display("write addr=%0d data=%0d", bus.addr_mov, bus.data_mov);
            wr_cnt++;
        end
        if (bus.pronto) begin
            pronto_num = bus.num_movimentos;
            $display("pronto num_movimentos=%0d", bus.num_movimentos);
            pronto_cnt++;
        end
        if (bus.db_estado >= 4'd3 && bus.db_estado <= 4'd7) past_start++;
        if (bus.db_estado == 4'd2) in_start++;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_iniciar();
        @(negedge clock);
        bus.iniciar = 1'b1;
        @(negedge clock);
        bus.iniciar = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic par_ok);
        logic [7:0] v;
        v = b;
        bus.rx_serial = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            bus.rx_serial = v[i];
            wait_cycles(CPB);
        end
`ifdef RECEPCAO_PARIDADE_EN
        bus.rx_serial = (^v) ^ ~par_ok;
        wait_cycles(CPB);
`else
        if (par_ok == 1'b0) $display("note: parity flag ignored in 8N1 build");
`endif
        bus.rx_serial = stop_bit;
        wait_cycles(CPB);
        bus.rx_serial = 1'b1;
        $display("sent byte 0x%02h stop=%0b", b, stop_bit);
    endtask

    int wb, pb, ps, is;

    initial begin
        bus.iniciar   = 1'b0;
        bus.rx_serial = 1'b1;

        // Reset state
        wait_cycles(3);
        check_val("rst_estado", {28'd0, bus.db_estado}, 32'd0);
        check_val("rst_we",     {31'd0, bus.we_mov}, 32'd0);
        check_val("rst_pronto", {31'd0, bus.pronto}, 32'd0);
        check_val("rst_erro",   {31'd0, bus.erro}, 32'd0);
        check_val("rst_num",    {23'd0, bus.num_movimentos}, 32'd0);
        check_val("rst_addr",   {23'd0, bus.addr_mov}, 32'd0);
        check_val("rst_data",   {27'd0, bus.data_mov}, 32'd0);
        reset = 1'b1;
        wait_cycles(3);

        // Normal list, back-to-back bytes
        wb = wr_cnt; pb = pronto_cnt;
        pulse_iniciar();
        check_val("norm_espera", {28'd0, bus.db_estado}, 32'd1);
        send_byte(8'h03, 1'b1, 1'b1);
        send_byte(8'h11, 1'b1, 1'b1);
        send_byte(8'h00, 1'b1, 1'b1);
        send_byte(8'hFF, 1'b1, 1'b1);
        wait_cycles(10);
        check_val("norm_nwr", wr_cnt - wb, 3);
        check_val("norm_a0", {23'd0, wr_addr[wb]},   32'd0);
        check_val("norm_d0", {27'd0, wr_data[wb]},   32'd3);
        check_val("norm_a1", {23'd0, wr_addr[wb+1]}, 32'd1);
        check_val("norm_d1", {27'd0, wr_data[wb+1]}, 32'd17);
        check_val("norm_a2", {23'd0, wr_addr[wb+2]}, 32'd2);
        check_val("norm_d2", {27'd0, wr_data[wb+2]}, 32'd0);
        check_val("norm_npronto", pronto_cnt - pb, 1);
        check_val("norm_pnum", {23'd0, pronto_num}, 32'd3);
        check_val("norm_num", {23'd0, bus.num_movimentos}, 32'd3);
        check_val("norm_erro", {31'd0, bus.erro}, 32'd0);
        check_val("norm_fim", {28'd0, bus.db_estado}, 32'd8);

        // Empty list
        wb = wr_cnt; pb = pronto_cnt;
        pulse_iniciar();
        send_byte(8'hFF, 1'b1, 1'b1);
        wait_cycles(10);
        check_val("empty_nwr", wr_cnt - wb, 0);
        check_val("empty_npronto", pronto_cnt - pb, 1);
        check_val("empty_pnum", {23'd0, pronto_num}, 32'd0);

        // Invalid code after one valid move
        wb = wr_cnt; pb = pronto_cnt;
        pulse_iniciar();
        send_byte(8'h05, 1'b1, 1'b1);
        send_byte(8'h12, 1'b1, 1'b1);
        wait_cycles(10);
        check_val("inv_nwr", wr_cnt - wb, 1);
        check_val("inv_a0", {23'd0, wr_addr[wb]}, 32'd0);
        check_val("inv_d0", {27'd0, wr_data[wb]}, 32'd5);
        check_val("inv_erro", {31'd0, bus.erro}, 32'd1);
        check_val("inv_npronto", pronto_cnt - pb, 0);
        check_val("inv_estado", {28'd0, bus.db_estado}, 32'd9);
        pulse_iniciar();
        check_val("inv_erro_clr", {31'd0, bus.erro}, 32'd0);
        check_val("inv_num_clr", {23'd0, bus.num_movimentos}, 32'd0);

        // Glitch: 2-cycle low pulse must not get past START
        ps = past_start; is = in_start;
        bus.rx_serial = 1'b0;
        wait_cycles(2);
        bus.rx_serial = 1'b1;
        wait_cycles(20);
        check_val("glitch_start", {31'd0, in_start > is}, 32'd1);
        check_val("glitch_past", past_start - ps, 0);
        check_val("glitch_estado", {28'd0, bus.db_estado}, 32'd1);

        // Framing error: stop bit low
        wb = wr_cnt;
        send_byte(8'h01, 1'b0, 1'b1);
        wait_cycles(10);
        check_val("frame_nwr", wr_cnt - wb, 0);
        check_val("frame_erro", {31'd0, bus.erro}, 32'd1);

        // Overflow at MAX_MOV=4
        wb = wr_cnt; pb = pronto_cnt;
        pulse_iniciar();
        for (int k = 0; k < 5; k++) send_byte(8'h01, 1'b1, 1'b1);
        wait_cycles(10);
        check_val("ovf_nwr", wr_cnt - wb, 4);
        for (int k = 0; k < 4; k++) begin
            check_val($sformatf("ovf_a%0d", k), {23'd0, wr_addr[wb+k]}, k);
            check_val($sformatf("ovf_d%0d", k), {27'd0, wr_data[wb+k]}, 32'd1);
        end
        check_val("ovf_erro", {31'd0, bus.erro}, 32'd1);
        check_val("ovf_npronto", pronto_cnt - pb, 0);

        // Reset in the middle of a byte
        wb = wr_cnt; pb = pronto_cnt;
        pulse_iniciar();
        send_byte(8'h02, 1'b1, 1'b1);
        wait_cycles(4);
        check_val("rmid_num_pre", {23'd0, bus.num_movimentos}, 32'd1);
        bus.rx_serial = 1'b0;
        wait_cycles(CPB);
        bus.rx_serial = 1'b1;
        wait_cycles(3 * CPB);
        check_val("rmid_dados", {28'd0, bus.db_estado}, 32'd3);
        reset = 1'b0;
        #1;
        check_val("rmid_estado", {28'd0, bus.db_estado}, 32'd0);
        check_val("rmid_num", {23'd0, bus.num_movimentos}, 32'd0);
        wait_cycles(2);
        reset = 1'b1;
        wait_cycles(4);
        pulse_iniciar();
        send_byte(8'h07, 1'b1, 1'b1);
        send_byte(8'hFF, 1'b1, 1'b1);
        wait_cycles(10);
        check_val("rmid_nwr", wr_cnt - wb, 2);
        check_val("rmid_a", {23'd0, wr_addr[wb+1]}, 32'd0);
        check_val("rmid_d", {27'd0, wr_data[wb+1]}, 32'd7);
        check_val("rmid_npronto", pronto_cnt - pb, 1);
        check_val("rmid_pnum", {23'd0, pronto_num}, 32'd1);

`ifdef RECEPCAO_PARIDADE_EN
        // Wrong parity bit
        wb = wr_cnt;
        pulse_iniciar();
        send_byte(8'h05, 1'b1, 1'b0);
        wait_cycles(10);
        check_val("par_nwr", wr_cnt - wb, 0);
        check_val("par_erro", {31'd0, bus.erro}, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/recepcao_movimentos.md
# recepcao_movimentos

Serial receiver that accepts the solution move list from the host solver and writes it into the move RAM (`ram_movimentos`, 480 × 5-bit) of the Rubik's Polibot datapath. It is the inbound counterpart of the colour transmitter (`transmissao_serial`). Colours go out to the host, and moves come back on `rx_serial`. It raises `pronto` (wired to `movimentos_recebidos`) when the host's end marker arrives, so the top FSM can start stepping through `contador_movimento`.

## Interface
- `CLKS_PER_BIT`, default 434 — clock cycles per UART bit (50 MHz / 115200).
- `MAX_MOV`, default 480 — RAM depth; maximum number of moves stored.
- `MAX_CODE`, default 17 — highest valid move code (6 faces × {CW, CCW, 180}).
- `END_CODE`, default 8'hFF — end-of-list byte.
- `clock` input 1 — single system clock; all logic rises on this edge.
- `reset` input 1 — asynchronous, active-low; 0 forces the reset state immediately.
- `iniciar` input 1 — one-cycle pulse that arms reception; honoured only in IDLE, FIM or ERRO.
- `rx_serial` input 1 — UART line, idle high, 8 data bits LSB first, 1 stop bit.
- `we_mov` output 1 — one-cycle RAM write strobe.
- `addr_mov` output 9 — RAM write address, equal to the current move count.
- `data_mov` output 5 — move code being written, `byte[4:0]`.
- `num_movimentos` output 9 — number of moves stored; stable after `pronto`.
- `pronto` output 1 — one-cycle pulse on reception of `END_CODE`.
- `erro` output 1 — level output, held until the next accepted `iniciar` or reset.
- `db_estado` output 4 — FSM state encoding, for debug displays.

## Operation
- `rx_serial` passes through a 2-flop synchronizer with an initialisation value of 1. All references to rx below mean the synchronized signal.
- FSM states: IDLE(0), ESPERA(1), START(2), DADOS(3), PARIDADE(4), STOP(5), AVALIA(6), ARMAZENA(7), FIM(8), ERRO(9).
- IDLE → ESPERA on `iniciar`. The same transition clears the move count and `erro`.
- ESPERA: the first cycle with rx = 0 moves the FSM to START and resets the bit timer.
- START: at the half-bit point, CLKS_PER_BIT/2 (integer division), rx is sampled.
  - rx = 1 means a glitch: return to ESPERA.
  - rx = 0 moves to DADOS.
- DADOS: 8 samples, one every CLKS_PER_BIT cycles, shifted in LSB first. After bit 7 the FSM goes to STOP, or to PARIDADE when that feature is compiled in.
- STOP: one sample, CLKS_PER_BIT after the previous sample.
  - 0 is a framing error: go to ERRO.
  - 1 goes to AVALIA.
- AVALIA, with checks taken in this order:
  1. byte == `END_CODE` → FIM. `pronto` pulses for one cycle and `num_movimentos` equals the count.
  2. byte > `MAX_CODE` → ERRO.
  3. count == `MAX_MOV` → ERRO (overflow).
  4. Otherwise → ARMAZENA.
- ARMAZENA: `we_mov`=1 for one cycle, with `addr_mov` = count and `data_mov` = `byte[4:0]`. The count increments at the end of the cycle, then the FSM returns to ESPERA.
- FIM and ERRO hold until `iniciar`, which behaves as it does from IDLE. `iniciar` in any other state is ignored.
- An empty list (`END_CODE` as the first byte) is valid: `pronto` pulses with `num_movimentos`=0.
- Reset values: FSM in IDLE; `we_mov`, `pronto`, `erro` = 0; `addr_mov`, `data_mov`, `num_movimentos`, count, timer and shift register = 0.
- Reset mid-byte aborts reception with no write. RAM contents are not touched, but the count returns to 0.

## Timing
- Let t0 be the cycle in which the synchronized rx first reads 0, which is 2 cycles after the pin falls.
- Start-bit sample: t0 + CLKS_PER_BIT/2.
- Data bit i sample: t0 + CLKS_PER_BIT/2 + (i+1)·CLKS_PER_BIT.
- Stop-bit sample: t0 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT, plus one extra bit period when parity is enabled.
- AVALIA occupies the cycle after the stop sample. `we_mov` or `pronto` is asserted the cycle after that.
- ESPERA is re-entered during the second half of the stop bit. Back-to-back bytes with no idle gap must be received without loss.
- `num_movimentos` tracks the count continuously. It is guaranteed stable from the `pronto` cycle onward.

## Configuration
- `RECEPCAO_PARIDADE_EN` defined: frame is 8E1. PARIDADE samples the bit after bit 7. If the XOR of the 8 data bits and the parity bit is 1, the FSM goes to ERRO before STOP.
- Undefined: frame is 8N1. PARIDADE is never entered, the code is compiled out, and `db_estado` never shows 4.

## Test plan
- Normal list: `iniciar`, then bytes 0x03, 0x11, 0x00, 0xFF at CLKS_PER_BIT=8. Expect 3 writes: (addr 0, 3), (1, 17), (2, 0). Then `pronto` pulses once with `num_movimentos`=3 and `erro`=0.
- Empty list: `iniciar`, then 0xFF. Expect no `we_mov`, `pronto` with `num_movimentos`=0.
- Invalid code: `iniciar`, then 0x05 and 0x12. Expect one write (addr 0, data 5), then `erro`=1 and no `pronto`. Expect `erro` to clear on the next `iniciar`.
- Framing and glitch: a 2-cycle low pulse on rx gives no state change past START. A byte with stop bit 0 gives `erro`=1 with no write.
- Overflow: with MAX_MOV=4, send 5 codes of 0x01. Expect writes to addresses 0–3, then `erro`=1 on the 5th byte.
- Reset mid-byte: drop `reset` during DADOS, release it, then `iniciar` and send 0x07, 0xFF. Expect a write at addr 0 with data 7 and `num_movimentos`=1. With `RECEPCAO_PARIDADE_EN` defined, a wrong parity bit gives `erro`=1.
